store_buffer: RTL

Posted-write buffer between the MEM pipeline stage and the byte-addressed data memory. Word stores from the pipeline are queued in a small FIFO and drained to the memory's write port one per cycle whenever the port is not needed by a load. Loads are given priority on the port and are forwarded from the buffer on an exact address match. Loads that overlap a queued store without matching it exactly raise a conflict that stalls the pipeline while the buffer drains.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/store_buffer_fifo.sv | 65 ++++++
 rtl/store_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory side of the pipeline.
// Includes the store-buffer entry format and the load/store overlap classifier.
package mips_mem_pkg;

   localparam int SB_DEPTH_DEFAULT = 4;
   localparam int WORD_BYTES       = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {
      OVL_NONE,
      OVL_EXACT,
      OVL_PARTIAL
   } ovl_t;

   // Two words overlap without matching when their byte addresses differ by less than a word.
   function automatic ovl_t classify(input logic [31:0] ld, input logic [31:0] st);
      logic [31:0] d;
      logic [31:0] nd;
      d  = ld - st;
      nd = st - ld;
      if (d == 32'd0)
         return OVL_EXACT;
      if (d < 32'(WORD_BYTES) || nd < 32'(WORD_BYTES))
         return OVL_PARTIAL;
      return OVL_NONE;
   endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Store-entry FIFO with entries exposed oldest-first; push lands next cycle, pop on posedge.
// Pushes into a full FIFO and pops of an empty FIFO are ignored; no full bypass.
module store_buffer_fifo
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  sb_entry_t               push_entry,
   input  logic                    pop,
   output sb_entry_t               entries [DEPTH],
   output logic [DEPTH-1:0]        entry_valid,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[tail] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push)
            tail <= tail + PTR_W'(1);
         if (do_pop)
            head <= head + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Slot k is the k-th oldest entry, so index 0 is always the head.
   for (genvar k = 0; k < DEPTH; k++) begin : g_ord
      logic [PTR_W-1:0] idx;
      assign idx            = head + PTR_W'(k);
      assign entries[k]     = mem[idx];
      assign entry_valid[k] = (CNT_W'(k) < count);
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: zero-cycle loads win the memory port, stores drain one per idle cycle.
// Forwarding on exact hits only when STORE_BUF_FWD_EN is defined; otherwise any overlap stalls via ld_conflict.
module store_buffer
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    st_valid,
   input  logic [31:0]             st_addr,
   input  logic [31:0]             st_data,
   output logic                    st_ready,
   input  logic                    ld_valid,
   input  logic [31:0]             ld_addr,
   output logic [31:0]             ld_data,
   output logic                    ld_conflict,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   output logic                    mem_write,
   output logic                    mem_read,
   input  logic [31:0]             mem_rdata,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   sb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] entry_valid;
   logic             full;
   logic             partial_any;
   logic             exact_any;

   assign st_ready = !full;

   store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (st_valid && st_ready),
      .push_entry  ('{addr: st_addr, data: st_data}),
      .pop         (mem_write),
      .entries     (entries),
      .entry_valid (entry_valid),
      .full        (full),
      .empty       (empty),
      .count       (count)
   );

   always_comb begin
      partial_any = 1'b0;
      exact_any   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_valid[k]) begin
            case (classify(ld_addr, entries[k].addr))
               OVL_EXACT:   exact_any   = 1'b1;
               OVL_PARTIAL: partial_any = 1'b1;
               default:     ;
            endcase
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [31:0] hit_data;

   // Scan runs oldest to youngest so the youngest matching store wins.
   always_comb begin
      hit_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_valid[k] && entries[k].addr == ld_addr)
            hit_data = entries[k].data;
      end
   end

   assign ld_conflict = ld_valid && partial_any;
   assign ld_data     = (exact_any && !ld_conflict) ? hit_data : mem_rdata;
`else
   assign ld_conflict = ld_valid && (partial_any || exact_any);
   assign ld_data     = mem_rdata;
`endif

   // A stalled load gives the port to the drain so the conflict clears.
   assign mem_read  = ld_valid && !ld_conflict;
   assign mem_write = !mem_read && !empty;
   assign mem_addr  = mem_read ? ld_addr : entries[0].addr;
   assign mem_wdata = entries[0].data;

endmodule
